pool_sequencer: RTL
===================

# pool_sequencer

Control sequencer for the streaming pooling datapath (comparator, running-max register, partial-row shift register, input mux). Consumes one pixel per `ce` cycle of an M×M row-major feature map. Tracks row, column and window band, and drives the mux select, shift-register load, max-register clear, output-valid and end-of-frame strobes. The result is (M/P)² non-overlapping P×P window results per frame.

## Interface
Parameters:
- `m`, 12: feature-map width and height in pixels, ≥ `p`.
- `p`, 3: pooling window edge, ≥ 2.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `master_rst`  in  1: reset, asynchronous and active-high.
- `ce`  in  1: a pixel is presented on the datapath this cycle. It is accepted when `ce && ready`.
- `ready`  out  1: sequencer can accept a pixel; low only in DONE.
- `sel`  out  2: mux select. 00 = running max, 01 = shift-register partial, 10 = neutral minimum, 11 unused.
- `load_sr`  out  1: shift register captures `comp_op` this edge.
- `rst_m`  out  1: clear the max register and multiplier.
- `valid_op`  out  1: `data_out` holds a completed window result.
- `global_rst`  out  1: one-cycle clear of the shift register.
- `end_op`  out  1: frame complete.

## Operation
- Counters:
  - `col` runs 0..m-1.
  - `row` runs 0..p-1 within the band.
  - `band` runs 0..m/p-1, plus the trailing-row region.
  - All counters are sized by `$clog2`.
- Derived terms:
  - `grp_first` = (col % p == 0).
  - `grp_last` = (col % p == p-1).
  - `in_win` = (col < (m/p)*p) and band < m/p. Remainder columns and rows are discarded.
- States:
  - IDLE: counters zero, `rst_m`=1. An accepted pixel is counted as pixel 0 and moves to RUN.
  - RUN: counters advance on each accepted pixel.
  - DONE: entered on the edge accepting pixel m*m-1.
    - DONE lasts exactly one cycle with `end_op`=1, `global_rst`=1, `ready`=0, `rst_m`=1.
    - It then returns to IDLE.
- `sel` is combinational from the counters of the pixel being presented:
  - 10 when `in_win && grp_first && row==0`.
  - 01 when `in_win && grp_first && row!=0`.
  - 00 otherwise.
- `load_sr` = accepted && `in_win && grp_last && row<p-1`. It is combinational and gated by `ce`.
- `valid_op` is registered. It is high for exactly the cycle after the edge that accepted a pixel with `in_win && grp_last && row==p-1`.
- Counter advance on accept:
  - `col` wraps at m-1, which increments `row`.
  - `row` wraps at p-1, which increments `band`, but only while band < m/p.
  - Trailing rows beyond (m/p)*p are counted by the frame pixel counter alone.
- Frame pixel counter: 0..m*m-1. Reaching m*m-1 on accept triggers DONE.
- `ce` low: all counters hold, `load_sr`=0, and no `valid_op` is generated.
- `ce` high while in DONE: the pixel is not accepted and not counted.

## Timing
- Reset values of all outputs:
  - `sel`=10.
  - `load_sr`=0, `valid_op`=0, `global_rst`=0, `end_op`=0.
  - `rst_m`=1, `ready`=1.
  - State IDLE, all counters 0.
- `master_rst` is asynchronous. Asserting it mid-frame immediately returns all outputs to their reset values and discards partial windows. The first pixel after deassertion is frame pixel 0.
- Latency: `valid_op` asserts 1 cycle after the last window pixel is accepted. `end_op` asserts 1 cycle after the last frame pixel is accepted.
- If the last frame pixel also completes a window, `valid_op` and `end_op` are high in the same cycle.
- `rst_m` is low throughout RUN.
- Back-to-back frames: the minimum gap is the single DONE cycle.

## Test plan
- m=12, p=3, 144 consecutive `ce`:
  - 16 `valid_op` pulses, the first in the cycle after pixel 26 and the last coincident with `end_op` after pixel 143.
  - `load_sr` fires 32 times.
  - `end_op` is high one cycle, then `ready`=1.
- Same frame with `ce` toggled every other cycle: identical pulse counts. `valid_op` occurs only after accepting edges, and counters hold in gaps.
- m=13, p=3:
  - column 12 and row 12 pixels give `sel`=00, `load_sr`=0 and no `valid_op`.
  - 16 valid results.
  - `end_op` after pixel 168.
- `sel` sequence check for m=12, p=3:
  - pixel 0 → 10, pixel 1 → 00.
  - pixel 12 → 01, pixel 36 → 10.
- `master_rst` pulsed at pixel 50 (mid-clock): outputs return to reset values within the same cycle. A fresh 144-pixel frame yields 16 `valid_op` pulses.
- `ce` held high through DONE: that pixel is not counted. The next frame's first `valid_op` follows its own pixel 26.

Source files
------------

// File: rtl/pool_sequencer_if.sv
// Control bundle between the pooling datapath and its sequencer.
// The datapath side drives ce; the sequencer drives every strobe back.
interface pool_sequencer_if;
    logic       ce;
    logic       ready;
    logic [1:0] sel;
    logic       load_sr;
    logic       rst_m;
    logic       valid_op;
    logic       global_rst;
    logic       end_op;
    logic [1:0] state;

    modport master (
        output ce,
        input  ready, sel, load_sr, rst_m, valid_op, global_rst, end_op, state
    );

    modport slave (
        input  ce,
        output ready, sel, load_sr, rst_m, valid_op, global_rst, end_op, state
    );
endinterface

// File: rtl/pool_sequencer.sv
// Sequencer for a streaming P x P non-overlapping max-pool over an M x M map.
// Tracks column, window-column phase, row-in-band, band and frame pixel index.
module pool_sequencer #(
    parameter int m = 12,
    parameter int p = 3
) (
    input  logic             clk,
    input  logic             master_rst,
    pool_sequencer_if.slave  bus
);
    // Handshake: a pixel is taken on a rising edge where ce && ready; ready
    // drops only for the single end-of-frame cycle, and a pixel offered then
    // is ignored rather than held.
    localparam int bands      = m / p;
    localparam int win        = bands * p;
    localparam int cw         = (m > 1) ? $clog2(m) : 1;
    localparam int rw         = $clog2(p);
    localparam int bw         = $clog2(bands + 1);
    localparam int fw         = $clog2(m * m);

    localparam logic [cw-1:0] col_last  = cw'(m - 1);
    localparam logic [cw:0]   win_col   = (cw + 1)'(win);
    localparam logic [cw-1:0] grp_lastv = cw'(p - 1);
    localparam logic [rw-1:0] row_last  = rw'(p - 1);
    localparam logic [bw-1:0] band_lim  = bw'(bands);
    localparam logic [fw-1:0] pix_last  = fw'(m * m - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [cw-1:0] col;
    logic [cw-1:0] gcol;
    logic [rw-1:0] row;
    logic [bw-1:0] band;
    logic [fw-1:0] pix;
    logic          valid_q;

    logic ready;
    logic accept;
    logic grp_first;
    logic grp_last;
    logic in_win;

    // gcol is col modulo p, kept as its own counter to avoid a divider.
    assign grp_first = (gcol == '0);
    assign grp_last  = (gcol == grp_lastv);
    assign in_win    = ({1'b0, col} < win_col) && (band < band_lim);
    assign ready     = (state != DONE);
    assign accept    = bus.ce && ready;

    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            state   <= IDLE;
            col     <= '0;
            gcol    <= '0;
            row     <= '0;
            band    <= '0;
            pix     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept && in_win && grp_last && (row == row_last);
            if (state == DONE) begin
                state <= IDLE;
            end else if (accept) begin
                if (pix == pix_last) begin
                    state <= DONE;
                    col   <= '0;
                    gcol  <= '0;
                    row   <= '0;
                    band  <= '0;
                    pix   <= '0;
                end else begin
                    state <= RUN;
                    pix   <= pix + fw'(1);
                    if (col == col_last) begin
                        col  <= '0;
                        gcol <= '0;
                        if (row == row_last) begin
                            row <= '0;
                            // Past the last full band only the pixel counter matters.
                            if (band < band_lim)
                                band <= band + bw'(1);
                        end else begin
                            row <= row + rw'(1);
                        end
                    end else begin
                        col  <= col + cw'(1);
                        gcol <= grp_last ? '0 : gcol + cw'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.sel = 2'b00;
        if (in_win && grp_first)
            bus.sel = (row == '0) ? 2'b10 : 2'b01;
    end

    assign bus.ready      = ready;
    assign bus.load_sr    = accept && in_win && grp_last && (row != row_last);
    assign bus.rst_m      = (state != RUN);
    assign bus.valid_op   = valid_q;
    assign bus.global_rst = (state == DONE);
    assign bus.end_op     = (state == DONE);
    assign bus.state      = state;
endmodule
